// File: rtl/mode_pin_conditioner.sv
// Synchronises and jointly debounces the raw M1/M0 mode pins into clean, glitch-free outputs.
// Optional rejected-glitch counter built when MODE_PIN_GLITCH_CNT_EN is defined.
module mode_pin_conditioner #(
  parameter logic [1:0]  DEFAULT_MODE    = 2'd3,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       internal_clk,
  input  logic       rst_n,
  input  logic       M0_pin,
  input  logic       M1_pin,
  output logic       M0,
  output logic       M1,
  output logic       mode_valid,
  output logic       mode_change_pulse
`ifdef MODE_PIN_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] m0_sync_q, m0_sync_d;
  logic [SYNC_STAGES-1:0] m1_sync_q, m1_sync_d;
  logic [1:0]             sync_code_c;
  state_t                 state_q, state_d;
  logic [1:0]             filt_q, filt_d;
  logic [1:0]             cand_q, cand_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   mode_valid_q, mode_valid_d;
  logic                   pulse_q, pulse_d;

  // Pin synchronisers: shift in at the LSB, consume the MSB.
  always_comb begin
    m0_sync_d = {m0_sync_q[SYNC_STAGES-2:0], M0_pin};
    m1_sync_d = {m1_sync_q[SYNC_STAGES-2:0], M1_pin};
  end

  assign sync_code_c = {m1_sync_q[SYNC_STAGES-1], m0_sync_q[SYNC_STAGES-1]};

  // Joint debounce of the 2-bit code; a further code change always restarts the count.
  always_comb begin
    state_d      = state_q;
    filt_d       = filt_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    mode_valid_d = mode_valid_q;
    pulse_d      = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync_code_c != filt_q) begin
          state_d      = ST_SETTLING;
          cand_d       = sync_code_c;
          cnt_d        = '0;
          mode_valid_d = 1'b0;
        end else begin
          mode_valid_d = 1'b1;
        end
      end
      ST_SETTLING: begin
        if (sync_code_c == filt_q) begin
          state_d      = ST_STABLE;
          mode_valid_d = 1'b1;
        end else if (sync_code_c != cand_q) begin
          cand_d = sync_code_c;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          filt_d       = cand_q;
          pulse_d      = 1'b1;
          mode_valid_d = 1'b1;
          state_d      = ST_STABLE;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_sync_q    <= {SYNC_STAGES{DEFAULT_MODE[0]}};
      m1_sync_q    <= {SYNC_STAGES{DEFAULT_MODE[1]}};
      state_q      <= ST_STABLE;
      filt_q       <= DEFAULT_MODE;
      cand_q       <= DEFAULT_MODE;
      cnt_q        <= '0;
      mode_valid_q <= 1'b1;
      pulse_q      <= 1'b0;
    end else begin
      m0_sync_q    <= m0_sync_d;
      m1_sync_q    <= m1_sync_d;
      state_q      <= state_d;
      filt_q       <= filt_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      mode_valid_q <= mode_valid_d;
      pulse_q      <= pulse_d;
    end
  end

  assign M0                = filt_q[0];
  assign M1                = filt_q[1];
  assign mode_valid        = mode_valid_q;
  assign mode_change_pulse = pulse_q;

`ifdef MODE_PIN_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_q, glitch_cnt_d;

  // Count returns to the filtered code without an accepted update, saturating.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if ((state_q == ST_SETTLING) && (sync_code_c == filt_q) && (glitch_cnt_q != 8'hFF)) begin
      glitch_cnt_d = glitch_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt_q <= 8'd0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  // Glitch counter not built in this configuration.
`endif

endmodule

// File: tb/tb_mode_pin_conditioner.sv
// Scoreboard bench for mode_pin_conditioner: run-length reference model feeds expectation queues,
// independent monitors pop and compare every cycle and on every mode_change_pulse.
module tb_mode_pin_conditioner;

  localparam int         SYNC = 2;
  localparam int         DEB  = 8;
  localparam logic [1:0] DEF  = 2'd3;
`ifdef MODE_PIN_GLITCH_CNT_EN
  localparam bit HAS_GC = 1'b1;
`else
  localparam bit HAS_GC = 1'b0;
`endif

  logic       internal_clk = 1'b0;
  logic       rst_n;
  logic       M0_pin, M1_pin;
  logic       M0, M1, mode_valid, mode_change_pulse;
  logic [7:0] gcnt_dut;

`ifdef MODE_PIN_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
  assign gcnt_dut = glitch_cnt;
`else
  assign gcnt_dut = 8'd0;
`endif

  mode_pin_conditioner #(
    .DEFAULT_MODE   (DEF),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .internal_clk     (internal_clk),
    .rst_n            (rst_n),
    .M0_pin           (M0_pin),
    .M1_pin           (M1_pin),
    .M0               (M0),
    .M1               (M1),
    .mode_valid       (mode_valid),
    .mode_change_pulse(mode_change_pulse)
`ifdef MODE_PIN_GLITCH_CNT_EN
    ,
    .glitch_cnt       (glitch_cnt)
`endif
  );

  always #5 internal_clk = ~internal_clk;

  typedef struct {
    logic [1:0] code;
    logic       valid;
    logic       pulse;
    logic [7:0] gcnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] pulse_q[$];
  logic [1:0] hist_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;

  // Reference model state: code seen by the debouncer is the pin value SYNC edges ago;
  // a code is accepted once it has been seen on DEB+1 consecutive edges.
  logic [1:0] m_filt   = DEF;
  logic [1:0] run_code = DEF;
  int         run_len  = 0;
  bit         m_prev_valid = 1'b1;
  int         m_gcnt   = 0;

  task automatic check(input bit ok, input string msg);
    n_checks++;
    if (!ok) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s", msg);
    end
  endtask

  function automatic void m_reset();
    hist_q.delete();
    for (int i = 0; i < SYNC; i++) hist_q.push_back(DEF);
    m_filt       = DEF;
    run_code     = DEF;
    run_len      = 0;
    m_prev_valid = 1'b1;
    m_gcnt       = 0;
    exp_q.delete();
    pulse_q.delete();
  endfunction

  function automatic void m_step(input logic [1:0] pins);
    logic [1:0] s;
    bit         pulse;
    bit         valid;
    exp_t       e;
    s = hist_q.pop_front();
    hist_q.push_back(pins);
    if (run_len > 0 && s == run_code) run_len++;
    else begin
      run_code = s;
      run_len  = 1;
    end
    pulse = 1'b0;
    if (run_code != m_filt && run_len >= DEB + 1) begin
      m_filt = run_code;
      pulse  = 1'b1;
      pulse_q.push_back(m_filt);
    end
    valid = (s == m_filt);
    if (valid && !pulse && !m_prev_valid && m_gcnt < 255) m_gcnt++;
    m_prev_valid = valid;
    e.code  = m_filt;
    e.valid = valid;
    e.pulse = pulse;
    e.gcnt  = HAS_GC ? 8'(m_gcnt) : 8'd0;
    exp_q.push_back(e);
  endfunction

  always @(posedge internal_clk) cyc <= cyc + 1;

  always @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step({M1_pin, M0_pin});
  end

  // Per-cycle output monitor.
  exp_t mon_e;
  always @(negedge internal_clk) begin
    if (rst_n && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check({M1, M0} == mon_e.code && mode_valid == mon_e.valid &&
            mode_change_pulse == mon_e.pulse && gcnt_dut == mon_e.gcnt,
            $sformatf("cycle_outputs cyc=%0d got code=%b valid=%b pulse=%b gcnt=%0d, expected code=%b valid=%b pulse=%b gcnt=%0d",
                      cyc, {M1, M0}, mode_valid, mode_change_pulse, gcnt_dut,
                      mon_e.code, mon_e.valid, mon_e.pulse, mon_e.gcnt));
    end
  end

  // Pulse monitor: every observed pulse must match the next accepted code.
  logic [1:0] mon_p;
  always @(negedge internal_clk) begin
    if (rst_n && mode_change_pulse) begin
      check(pulse_q.size() != 0, $sformatf("pulse_expected cyc=%0d got unexpected pulse code=%b, expected no pulse", cyc, {M1, M0}));
      if (pulse_q.size() != 0) begin
        mon_p = pulse_q.pop_front();
        check({M1, M0} == mon_p, $sformatf("pulse_code cyc=%0d got %b expected %b", cyc, {M1, M0}, mon_p));
      end
    end
  end

  task automatic hold(input logic [1:0] code, input int n);
    M1_pin = code[1];
    M0_pin = code[0];
    repeat (n) begin
      @(posedge internal_clk);
      #2;
    end
  endtask

  task automatic check_reset(input string name);
    check({M1, M0} == DEF && mode_valid && !mode_change_pulse && gcnt_dut == 8'd0,
          $sformatf("%s got code=%b valid=%b pulse=%b gcnt=%0d, expected code=%b valid=1 pulse=0 gcnt=0",
                    name, {M1, M0}, mode_valid, mode_change_pulse, gcnt_dut, DEF));
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    check_reset(name);
    @(posedge internal_clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for the update pulse and checks its edge against s0.
  task automatic wait_update(input int s0, input int lat, input int vlat, input logic [1:0] code,
                             input string name);
    int vlow = -1;
    int pcyc = -1;
    for (int i = 0; i < 60 && pcyc < 0; i++) begin
      @(negedge internal_clk);
      if (!mode_valid && vlow < 0) vlow = cyc;
      if (mode_change_pulse) pcyc = cyc;
    end
    check(pcyc == s0 + lat, $sformatf("%s_latency got edge %0d expected edge %0d", name, pcyc, s0 + lat));
    check({M1, M0} == code, $sformatf("%s_code got %b expected %b", name, {M1, M0}, code));
    if (vlat >= 0)
      check(vlow == s0 + vlat, $sformatf("%s_valid_drop got edge %0d expected edge %0d", name, vlow, s0 + vlat));
    @(posedge internal_clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst_n  = 1'b0;
    M0_pin = 1'b1;
    M1_pin = 1'b1;
    @(posedge internal_clk);
    #2;
    check_reset("por_reset");
    @(posedge internal_clk);
    #2;
    rst_n = 1'b1;
    hold(2'b11, 5);

    // Clean switch 3->0 and back.
    s0 = cyc + 1;
    hold(2'b00, 0);
    wait_update(s0, SYNC + DEB, SYNC, 2'b00, "clean_3to0");
    hold(2'b00, 3);
    s0 = cyc + 1;
    hold(2'b11, 0);
    wait_update(s0, SYNC + DEB, SYNC, 2'b11, "clean_0to3");
    hold(2'b11, 4);

    do_reset("midrun_reset");
    hold(2'b11, 4);

    // Short M0 glitch is rejected.
    hold(2'b10, 5);
    hold(2'b11, 20);
    check({M1, M0} == 2'b11 && mode_valid && gcnt_dut == (HAS_GC ? 8'd1 : 8'd0),
          $sformatf("glitch_reject got code=%b valid=%b gcnt=%0d expected code=11 valid=1 gcnt=%0d",
                    {M1, M0}, mode_valid, gcnt_dut, HAS_GC ? 1 : 0));

    // Skewed pins: M0 first, M1 three cycles later.
    s0 = cyc + 1;
    hold(2'b10, 3);
    hold(2'b00, 0);
    wait_update(s0, 3 + SYNC + DEB, -1, 2'b00, "skewed_3to0");
    hold(2'b00, 3);
    s0 = cyc + 1;
    hold(2'b11, 0);
    wait_update(s0, SYNC + DEB, SYNC, 2'b11, "back_to_3");
    hold(2'b11, 3);

    // Reset while settling on 2; pins stay at 2.
    hold(2'b10, 6);
    do_reset("settling_reset");
    s0 = cyc + 1;
    wait_update(s0, SYNC + DEB, SYNC, 2'b10, "after_reset_3to2");
    hold(2'b10, 3);
    s0 = cyc + 1;
    hold(2'b11, 0);
    wait_update(s0, SYNC + DEB, SYNC, 2'b11, "restore_3");
    do_reset("pre_saturation_reset");
    hold(2'b11, 3);

    // Saturate the glitch counter.
    for (int i = 0; i < 300; i++) begin
      hold(2'b10, 3);
      hold(2'b11, 4);
    end
    hold(2'b11, 5);
    check({M1, M0} == 2'b11 && gcnt_dut == (HAS_GC ? 8'd255 : 8'd0),
          $sformatf("glitch_saturation got code=%b gcnt=%0d expected code=11 gcnt=%0d",
                    {M1, M0}, gcnt_dut, HAS_GC ? 255 : 0));

    // Random pin activity with occasional resets.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 29) == 0) do_reset("random_reset");
      hold(2'($urandom_range(0, 3)), $urandom_range(1, 16));
    end
    hold(2'b11, 30);
    check(pulse_q.size() == 0, $sformatf("pending_pulses got %0d outstanding expected 0", pulse_q.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
